dmem_arbiter: RTL and testbench



---
 rtl/dmem_pkg.sv | 38 +++
 rtl/dmem_lane.sv | 43 ++++
 rtl/dmem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes, FSM states,
// default RAM address width and small alignment helpers.
package dmem_pkg;

    localparam int ADDR_W_DEF = 11;

    // Access size as presented on rqN_size; the reserved code behaves as a word.
    typedef enum logic [1:0] {
        SIZE_WORD = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_BYTE = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_RMW_WR = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR    = 3'd4
    } state_e;

    // A byte can never be misaligned; halves need an even address; words
    // (and the reserved size) need a 4-byte aligned address.
    function automatic logic is_misaligned(input size_e size, input logic [1:0] off);
        case (size)
            SIZE_HALF: return off[0];
            SIZE_BYTE: return 1'b0;
            default:   return (off != 2'b00);
        endcase
    endfunction

    // Byte and halfword stores need a read-modify-write of the full RAM word.
    function automatic logic is_subword(input size_e size);
        return (size == SIZE_HALF) || (size == SIZE_BYTE);
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Lane logic between the 32-bit RAM word and a sized access:
// merges store data into the addressed lane and extracts/extends load data.
module dmem_lane
    import dmem_pkg::*;
(
    input  size_e       size,
    input  logic        zext,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_word,
    output logic [31:0] merge_word,
    output logic [31:0] load_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane and extend it to 32 bits for loads.
    always_comb begin
        byte_sel  = mem_word[{off, 3'b000} +: 8];
        half_sel  = off[1] ? mem_word[31:16] : mem_word[15:0];
        load_word = mem_word;
        case (size)
            SIZE_BYTE: load_word = zext ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SIZE_HALF: load_word = zext ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default:   load_word = mem_word;
        endcase
    end

    // Replace only the addressed lane of the old word; full words pass store data through.
    always_comb begin
        merge_word = mem_word;
        case (size)
            SIZE_BYTE: merge_word[{off, 3'b000} +: 8] = wdata[7:0];
            SIZE_HALF: begin
                if (off[1]) merge_word[31:16] = wdata[15:0];
                else        merge_word[15:0]  = wdata[15:0];
            end
            default:   merge_word = wdata;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous data RAM.
// One command is in flight at a time; sub-word stores use read-modify-write.
// Handshake: in IDLE the arbiter raises rqN_ready for exactly one cycle on the
// granted port while its rqN_valid is high; the command is captured on that
// clock edge and the requester inputs are ignored until the next grant.
// The command later finishes with a one-cycle rqN_done (plus rqN_err/rqN_rdata)
// on the same port only.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rq0_valid,
    output logic              rq0_ready,
    input  logic              rq0_we,
    input  logic [1:0]        rq0_size,
    input  logic              rq0_zext,
    input  logic [31:0]       rq0_addr,
    input  logic [31:0]       rq0_wdata,
    output logic              rq0_done,
    output logic              rq0_err,
    output logic [31:0]       rq0_rdata,
    input  logic              rq1_valid,
    output logic              rq1_ready,
    input  logic              rq1_we,
    input  logic [1:0]        rq1_size,
    input  logic              rq1_zext,
    input  logic [31:0]       rq1_addr,
    input  logic [31:0]       rq1_wdata,
    output logic              rq1_done,
    output logic              rq1_err,
    output logic [31:0]       rq1_rdata,
    output logic              mem_ena,
    output logic              mem_wena,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef struct packed {
        logic              port;
        logic              we;
        size_e             size;
        logic              zext;
        logic [ADDR_W+1:0] addr;
        logic [31:0]       wdata;
    } cmd_t;

    state_e      state_q, state_d;
    cmd_t        cmd_q, cmd_d;
    logic        last_q, last_d;

    logic        grant;
    logic [1:0]  rdy;
    logic        fsm_done, fsm_err, fsm_ena, fsm_wena;
    logic [31:0] fsm_rdata;
    logic [31:0] merge_word, load_word;

    dmem_lane u_lane (
        .size       (cmd_q.size),
        .zext       (cmd_q.zext),
        .off        (cmd_q.addr[1:0]),
        .wdata      (cmd_q.wdata),
        .mem_word   (mem_rdata),
        .merge_word (merge_word),
        .load_word  (load_word)
    );

    // State, captured command and round-robin pointer; reset lets port 0 win the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            last_q  <= last_d;
        end
    end

    // Next-state, grant and RAM control decode.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        last_d    = last_q;
        grant     = 1'b0;
        rdy       = 2'b00;
        fsm_done  = 1'b0;
        fsm_err   = 1'b0;
        fsm_ena   = 1'b0;
        fsm_wena  = 1'b0;
        fsm_rdata = 32'h0;
        case (state_q)
            ST_IDLE: begin
                if (rq0_valid || rq1_valid) begin
                    // A tie goes to the port not granted last; a lone request wins outright.
                    grant = (rq0_valid && rq1_valid) ? ~last_q : rq1_valid;
                    if (grant) begin
                        cmd_d = '{port: 1'b1, we: rq1_we, size: size_e'(rq1_size), zext: rq1_zext,
                                  addr: rq1_addr[ADDR_W+1:0], wdata: rq1_wdata};
                        rdy   = 2'b10;
                    end else begin
                        cmd_d = '{port: 1'b0, we: rq0_we, size: size_e'(rq0_size), zext: rq0_zext,
                                  addr: rq0_addr[ADDR_W+1:0], wdata: rq0_wdata};
                        rdy   = 2'b01;
                    end
                    last_d  = grant;
                    state_d = is_misaligned(cmd_d.size, cmd_d.addr[1:0]) ? ST_ERR : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Sub-word stores read here and write in RMW_WR; everything else finishes directly.
                fsm_ena  = 1'b1;
                fsm_wena = cmd_q.we && !is_subword(cmd_q.size);
                state_d  = (cmd_q.we && is_subword(cmd_q.size)) ? ST_RMW_WR : ST_DONE;
            end
            ST_RMW_WR: begin
                fsm_ena  = 1'b1;
                fsm_wena = 1'b1;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                fsm_done  = 1'b1;
                fsm_rdata = cmd_q.we ? 32'h0 : load_word;
                state_d   = ST_IDLE;
            end
            ST_ERR: begin
                fsm_done = 1'b1;
                fsm_err  = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Route decode to the ports; reset blanks every output in the same cycle so an
    // aborted command can neither write the RAM nor signal completion.
    always_comb begin
        rq0_ready = 1'b0;
        rq1_ready = 1'b0;
        rq0_done  = 1'b0;
        rq1_done  = 1'b0;
        rq0_err   = 1'b0;
        rq1_err   = 1'b0;
        rq0_rdata = 32'h0;
        rq1_rdata = 32'h0;
        mem_ena   = 1'b0;
        mem_wena  = 1'b0;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        if (!rst) begin
            rq0_ready = rdy[0];
            rq1_ready = rdy[1];
            mem_ena   = fsm_ena;
            mem_wena  = fsm_wena;
            mem_addr  = cmd_q.addr[ADDR_W+1:2];
            mem_wdata = (state_q == ST_RMW_WR) ? merge_word : cmd_q.wdata;
            if (cmd_q.port) begin
                rq1_done  = fsm_done;
                rq1_err   = fsm_err;
                rq1_rdata = fsm_rdata;
            end else begin
                rq0_done  = fsm_done;
                rq0_err   = fsm_err;
                rq0_rdata = fsm_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a small synchronous RAM, two port drivers, a
// byte-level reference memory and a scoreboard of expected completions and writes.
module tb_dmem_arbiter;

    localparam int ADDR_W = 11;

    typedef struct packed {
        logic        port;
        logic        err;
        logic [31:0] rdata;
        logic [19:0] done_cyc;
        logic [3:0]  ena;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              rq0_valid, rq0_ready, rq0_we, rq0_zext, rq0_done, rq0_err;
    logic [1:0]        rq0_size;
    logic [31:0]       rq0_addr, rq0_wdata, rq0_rdata;
    logic              rq1_valid, rq1_ready, rq1_we, rq1_zext, rq1_done, rq1_err;
    logic [1:0]        rq1_size;
    logic [31:0]       rq1_addr, rq1_wdata, rq1_rdata;
    logic              mem_ena, mem_wena;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;

    logic [31:0]       ram [0:(1<<ADDR_W)-1];
    logic [7:0]        ref_bytes [0:(4<<ADDR_W)-1];
    logic              pl_en;
    logic [ADDR_W-1:0] pl_addr;
    logic [31:0]       pl_data;

    logic [$bits(exp_t)-1:0] exp_q[$];
    logic [ADDR_W+31:0]      wr_q[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ena_cnt = 0;
    logic last_m = 1'b1;
    exp_t m_e;
    logic [ADDR_W+31:0] m_w;
    logic [1:0]  m_gnt;
    logic [31:0] m_rd;

    dmem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .rq0_valid (rq0_valid),
        .rq0_ready (rq0_ready),
        .rq0_we    (rq0_we),
        .rq0_size  (rq0_size),
        .rq0_zext  (rq0_zext),
        .rq0_addr  (rq0_addr),
        .rq0_wdata (rq0_wdata),
        .rq0_done  (rq0_done),
        .rq0_err   (rq0_err),
        .rq0_rdata (rq0_rdata),
        .rq1_valid (rq1_valid),
        .rq1_ready (rq1_ready),
        .rq1_we    (rq1_we),
        .rq1_size  (rq1_size),
        .rq1_zext  (rq1_zext),
        .rq1_addr  (rq1_addr),
        .rq1_wdata (rq1_wdata),
        .rq1_done  (rq1_done),
        .rq1_err   (rq1_err),
        .rq1_rdata (rq1_rdata),
        .mem_ena   (mem_ena),
        .mem_wena  (mem_wena),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM with read-before-write; a preload port fills it during reset.
    always @(posedge clk) begin
        if (pl_en) begin
            ram[pl_addr] <= pl_data;
        end else if (mem_ena) begin
            if (mem_wena) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    // Reference: computes the expected completion and RAM write of an accepted
    // command from a little-endian byte image of memory.
    task automatic model_cmd(input logic port, input logic we, input logic [1:0] size,
                             input logic zext, input logic [31:0] addr,
                             input logic [31:0] wdata, input int acc);
        exp_t e;
        int n;
        int b;
        logic [31:0] v;
        logic [ADDR_W-1:0] wa;
        n = (size == 2'b01) ? 2 : ((size == 2'b10) ? 1 : 4);
        b = int'(addr[ADDR_W+1:0]);
        e = '0;
        e.port = port;
        if ((b % n) != 0) begin
            e.err      = 1'b1;
            e.done_cyc = 20'(acc + 1);
            e.ena      = 4'd0;
        end else if (we) begin
            for (int i = 0; i < n; i++) ref_bytes[b + i] = wdata[8*i +: 8];
            wa = addr[ADDR_W+1:2];
            v  = {ref_bytes[{wa, 2'b11}], ref_bytes[{wa, 2'b10}],
                  ref_bytes[{wa, 2'b01}], ref_bytes[{wa, 2'b00}]};
            wr_q.push_back({wa, v});
            e.done_cyc = 20'(acc + ((n == 4) ? 2 : 3));
            e.ena      = (n == 4) ? 4'd1 : 4'd2;
        end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[b + i]) << (8 * i));
            if (!zext && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
            e.rdata    = v;
            e.done_cyc = 20'(acc + 2);
            e.ena      = 4'd1;
        end
        exp_q.push_back(e);
    endtask

    task automatic drive_port(input logic port, input logic v, input logic we,
                              input logic [1:0] size, input logic zext,
                              input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 1'b0) begin
            rq0_valid = v; rq0_we = we; rq0_size = size; rq0_zext = zext;
            rq0_addr = addr; rq0_wdata = wdata;
        end else begin
            rq1_valid = v; rq1_we = we; rq1_size = size; rq1_zext = zext;
            rq1_addr = addr; rq1_wdata = wdata;
        end
    endtask

    // Present one request; called just after a rising edge, returns just after the
    // edge that accepted it, leaving garbage on the now don't-care inputs.
    task automatic issue(input logic port, input logic we, input logic [1:0] size,
                         input logic zext, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit track);
        int waited;
        bit got;
        drive_port(port, 1'b1, we, size, zext, addr, wdata);
        waited = 0;
        got = 0;
        while (!got && waited < 60) begin
            @(negedge clk);
            if ((port == 1'b0 && rq0_ready === 1'b1) || (port == 1'b1 && rq1_ready === 1'b1)) got = 1;
            else waited++;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL grant_timeout: port %0d ready stayed low for %0d cycles, required an accept", port, waited);
        end else if (track) begin
            model_cmd(port, we, size, zext, addr, wdata, cyc);
        end
        @(posedge clk);
        #1;
        drive_port(port, 1'b0, 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
    endtask

    task automatic rand_issue(input logic port);
        logic [31:0] a;
        a = {19'($urandom), 7'd0, 6'($urandom_range(0, 63))};
        issue(port, 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom, 1'b1);
    endtask

    // Monitor: RAM writes, grants and completions against the scoreboard.
    always @(negedge clk) begin
        if (mem_ena) ena_cnt++;
        if (mem_ena && mem_wena) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: addr=%h data=%h, required no write", mem_addr, mem_wdata);
            end else begin
                m_w = wr_q.pop_front();
                if ({mem_addr, mem_wdata} !== m_w) begin
                    errors++;
                    $display("FAIL write_data: addr=%h data=%h, required addr=%h data=%h",
                             mem_addr, mem_wdata, m_w[ADDR_W+31:32], m_w[31:0]);
                end
            end
        end
        if (!rst && (rq0_ready || rq1_ready)) begin
            checks++;
            if (rq0_valid && rq1_valid) m_gnt = last_m ? 2'b01 : 2'b10;
            else m_gnt = rq1_valid ? 2'b10 : 2'b01;
            if ({rq1_ready, rq0_ready} !== m_gnt) begin
                errors++;
                $display("FAIL grant: ready{1,0}=%b, required %b (valid{1,0}=%b%b)",
                         {rq1_ready, rq0_ready}, m_gnt, rq1_valid, rq0_valid);
            end
            last_m = m_gnt[1];
        end
        if (rq0_done || rq1_done || rq0_err || rq1_err) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: done{1,0}=%b%b err{1,0}=%b%b, required none",
                         rq1_done, rq0_done, rq1_err, rq0_err);
            end else begin
                m_e  = exp_t'(exp_q.pop_front());
                m_rd = m_e.port ? rq1_rdata : rq0_rdata;
                if ({rq1_done, rq0_done} !== (m_e.port ? 2'b10 : 2'b01) ||
                    {rq1_err, rq0_err} !== (m_e.err ? (m_e.port ? 2'b10 : 2'b01) : 2'b00) ||
                    m_rd !== m_e.rdata || 20'(cyc) !== m_e.done_cyc || 4'(ena_cnt) !== m_e.ena) begin
                    errors++;
                    $display("FAIL completion: done=%b%b err=%b%b rdata=%h cyc=%0d ena=%0d, required port=%0d err=%b rdata=%h cyc=%0d ena=%0d",
                             rq1_done, rq0_done, rq1_err, rq0_err, m_rd, cyc, ena_cnt,
                             m_e.port, m_e.err, m_e.rdata, m_e.done_cyc, m_e.ena);
                end
            end
            ena_cnt = 0;
        end
        if (rst) begin
            last_m  = 1'b1;
            ena_cnt = 0;
        end
    end

    // Stimulus: reset with preload, directed cases, abort, contention, random mix.
    initial begin
        rst = 1'b1;
        pl_en = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        drive_port(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0004, 32'hFFFF_FFFF);
        drive_port(1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_0008, 32'hAAAA_5555);
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            pl_en   = 1'b1;
            pl_addr = ADDR_W'(i);
            pl_data = (i == 1) ? 32'h1280_3456 : ((i == 2) ? 32'h1122_3344 : $urandom);
            for (int k = 0; k < 4; k++) ref_bytes[i*4 + k] = pl_data[8*k +: 8];
            @(posedge clk);
            #1;
        end
        pl_en = 1'b0;
        @(negedge clk);
        checks++;
        if ({rq0_ready, rq1_ready, rq0_done, rq1_done, rq0_err, rq1_err, mem_ena, mem_wena} !== 8'h00 ||
            rq0_rdata !== 32'h0 || rq1_rdata !== 32'h0 || mem_addr !== '0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b%b done=%b%b err=%b%b ena=%b wena=%b addr=%h wdata=%h, required all zero",
                     rq1_ready, rq0_ready, rq1_done, rq0_done, rq1_err, rq0_err, mem_ena, mem_wena, mem_addr, mem_wdata);
        end
        @(posedge clk);
        #1;
        rq0_valid = 1'b0;
        rq1_valid = 1'b0;
        rst = 1'b0;

        // Signed byte load, halfword store RMW, misaligned word load.
        issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 1'b1);
        issue(1'b1, 1'b1, 2'b01, 1'b0, 32'h0000_000A, 32'h0000_BEEF, 1'b1);
        issue(1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0002, 32'h0, 1'b1);
        issue(1'b0, 1'b0, 2'b01, 1'b1, 32'h0000_000A, 32'h0, 1'b1);

        // Reset in the write cycle of a sub-word store aborts it cleanly.
        issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0011, 32'h0000_00C3, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_wena !== 1'b0 || rq0_done !== 1'b0 || rq1_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_cycle: wena=%b done=%b%b, required 0 and 00", mem_wena, rq1_done, rq0_done);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        fork
            issue(1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'h0, 1'b1);
            issue(1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_0011, 32'h0, 1'b1);
            begin
                @(negedge clk);
                checks++;
                if (rq0_ready !== 1'b1 || rq1_ready !== 1'b0 || rq0_done !== 1'b0 || rq1_done !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_recover: ready=%b%b done=%b%b, required ready=01 done=00",
                             rq1_ready, rq0_ready, rq1_done, rq0_done);
                end
            end
        join

        // Both ports continuously requesting alternate grants.
        fork
            begin
                issue(1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0004, 32'h0, 1'b1);
                issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0014, 32'hCAFE_F00D, 1'b1);
            end
            begin
                issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0016, 32'h0, 1'b1);
                issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0017, 32'h0000_005A, 1'b1);
            end
        join

        // Random mix of single-port and contending requests.
        for (int r = 0; r < 120; r++) begin
            case ($urandom_range(0, 2))
                0: rand_issue(1'b0);
                1: rand_issue(1'b1);
                default: fork
                    rand_issue(1'b0);
                    rand_issue(1'b1);
                join
            endcase
        end

        repeat (10) @(posedge clk);
        checks++;
        if (exp_q.size() != 0 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d completions and %0d writes outstanding, required 0 and 0",
                     exp_q.size(), wr_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded its time budget, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
